// File: rtl/sobel_ctrl.sv
// Frame sequencer for the Sobel compute stage: fetches prev/curr/next row words, strobes loads and
// shifts, writes results back with a one-group lag plus a per-row flush. One memory access in flight.
module sobel_ctrl #(
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int ADDR_W   = 16,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 'h1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic              mem_stb_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_dat_o,
    input  logic [31:0]       mem_dat_i,
    input  logic              mem_ack_i,
    output logic [31:0]       dat_o,
    output logic              prev_row_load_o,
    output logic              curr_row_load_o,
    output logic              next_row_load_o,
    output logic              shift_en_o,
    input  logic [31:0]       result_i
);
    localparam int WPR = IMG_W / 4;
    localparam int GW  = (WPR > 2) ? $clog2(WPR) : 1;
    localparam int RW  = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] WPR_A = ADDR_W'(WPR);
    localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);

    typedef enum logic [2:0] {IDLE, RD_PREV, RD_CURR, RD_NEXT, SHIFT, WR, FLUSH, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        sh_cnt;
    logic [GW-1:0]     g;
    logic [RW-1:0]     r;
    logic [ADDR_W-1:0] row_base;   // r * WPR, kept incrementally
    logic              tail;       // set once the flush is done: the pending write is the row's last word
    logic              ack, shift_last, last_row, last_grp;

    assign ack        = mem_ack_i & mem_stb_o;
    // The SHIFT cycle that carries the next-row load is the load-settle cycle; no shift there.
    assign shift_en_o = (state == SHIFT && !next_row_load_o) || state == FLUSH;
    assign shift_last = shift_en_o && sh_cnt == 2'd3;
    assign last_row   = r == RW'(IMG_H - 2);
    assign last_grp   = g == GW'(WPR - 1);

    assign busy_o    = state != IDLE;
    assign done_o    = state == DONE;
    assign mem_stb_o = state == RD_PREV || state == RD_CURR || state == RD_NEXT || state == WR;
    assign mem_we_o  = state == WR;
    assign mem_dat_o = (state == WR) ? result_i : 32'h0;

    always_comb begin
        mem_adr_o = '0;
        case (state)
            RD_PREV: mem_adr_o = SRC_A + row_base - WPR_A + ADDR_W'(g);
            RD_CURR: mem_adr_o = SRC_A + row_base + ADDR_W'(g);
            RD_NEXT: mem_adr_o = SRC_A + row_base + WPR_A + ADDR_W'(g);
            WR:      mem_adr_o = DST_A + row_base + ADDR_W'(g) - (tail ? '0 : ADDR_W'(1));
            default: mem_adr_o = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RD_PREV;
            RD_PREV: if (ack) state_nxt = RD_CURR;
            RD_CURR: if (ack) state_nxt = RD_NEXT;
            RD_NEXT: if (ack) state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = (g == '0) ? RD_PREV : WR;
            FLUSH:   if (shift_last) state_nxt = WR;
            WR: begin
                if (ack) begin
                    if (tail)          state_nxt = last_row ? DONE : RD_PREV;
                    else if (last_grp) state_nxt = FLUSH;
                    else               state_nxt = RD_PREV;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            sh_cnt          <= 2'd0;
            g               <= '0;
            r               <= RW'(1);
            row_base        <= WPR_A;
            tail            <= 1'b0;
            dat_o           <= 32'h0;
            prev_row_load_o <= 1'b0;
            curr_row_load_o <= 1'b0;
            next_row_load_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            prev_row_load_o <= ack && state == RD_PREV;
            curr_row_load_o <= ack && state == RD_CURR;
            next_row_load_o <= ack && state == RD_NEXT;
            if (ack && !mem_we_o) dat_o <= mem_dat_i;
            if (shift_en_o) sh_cnt <= sh_cnt + 2'd1;
            if (state == SHIFT && shift_last && g == '0) g <= g + GW'(1);
            if (state == FLUSH && shift_last) tail <= 1'b1;
            if (state == WR && ack) begin
                if (tail) begin
                    tail <= 1'b0;
                    g    <= '0;
                    if (last_row) begin
                        r        <= RW'(1);
                        row_base <= WPR_A;
                    end else begin
                        r        <= r + RW'(1);
                        row_base <= row_base + WPR_A;
                    end
                end else if (!last_grp) begin
                    g <= g + GW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sobel_ctrl.sv
// Bench for sobel_ctrl: latency-randomised memory responder, transaction scoreboard, strobe timing checks.
module tb_sobel_ctrl;
    localparam int W = 8, H = 4, WPR = 2, DST = 16;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, stb, we;
    logic [15:0] adr;
    logic [31:0] wdat, rdat, dat, result;
    logic        ack;
    logic        ld_prev, ld_curr, ld_next, shift_en;

    sobel_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .SRC_BASE(0), .DST_BASE(DST)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .mem_adr_o(adr), .mem_stb_o(stb), .mem_we_o(we), .mem_dat_o(wdat),
        .mem_dat_i(rdat), .mem_ack_i(ack), .dat_o(dat),
        .prev_row_load_o(ld_prev), .curr_row_load_o(ld_curr), .next_row_load_o(ld_next),
        .shift_en_o(shift_en), .result_i(result)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; int adr; logic [31:0] dat; } txn_t;
    typedef struct { int max_lat; bit spam; int exp_cyc; int exp_rd; int exp_wr; } vec_t;

    txn_t        sb[$];
    int          checks = 0, errors = 0;
    int          rd_n, wr_n, shifts, done_n, log_n, max_lat = 1, lat = 1, cnt = 0;
    int          log_adr[8];
    logic [31:0] last_rd;
    logic        spur = 1'b0, p_stb = 1'b0, p_ack = 1'b0;
    logic [48:0] p_bus;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder and output monitors, all evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            ack = 1'b0;
            cnt = 0;
        end else begin
            if (ld_prev | ld_curr | ld_next) begin
                check("load_strobe", 64'({ld_prev, ld_curr, ld_next}), 64'(3'b100 >> ((rd_n - 1) % 3)));
                check("load_dat", 64'(dat), 64'(last_rd));
                check("load_shift_excl", 64'(shift_en), 64'(0));
            end
            if (stb && p_stb && !p_ack)
                check("bus_stable", 64'({adr, we, wdat}), 64'(p_bus));
            if (shift_en) begin
                shifts++;
                result = {16'h5EED, 16'(shifts)};
            end
            if (done) done_n++;
            if (ack) ack = 1'b0;
            if (stb) begin
                cnt++;
                if (cnt > lat) begin
                    ack = 1'b1;
                    cnt = 0;
                    lat = $urandom_range(1, max_lat);
                    if (log_n < 8) log_adr[log_n] = int'(adr);
                    log_n++;
                    if (we) wr_n++;
                    else begin
                        rdat    = 32'hC0DE_0000 ^ {16'h0, adr};
                        last_rd = rdat;
                        rd_n++;
                    end
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL txn_extra: got we=%0b adr=%0h expected none", we, adr);
                    end else begin
                        txn_t e;
                        e = sb.pop_front();
                        check("txn_adr", 64'({we, adr}), 64'({e.we, 16'(e.adr)}));
                        if (e.we) check("wr_dat", 64'(wdat), 64'(e.dat));
                    end
                end
            end
            if (spur) ack = 1'b1;
        end
        p_stb = stb & ~rst;
        p_ack = ack;
        p_bus = {adr, we, wdat};
    end

    task automatic prep();
        sb.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int g = 0; g < WPR; g++) begin
                sb.push_back('{1'b0, (r - 1) * WPR + g, 32'h0});
                sb.push_back('{1'b0, r * WPR + g, 32'h0});
                sb.push_back('{1'b0, (r + 1) * WPR + g, 32'h0});
                if (g >= 1)
                    sb.push_back('{1'b1, DST + r * WPR + g - 1,
                                   {16'h5EED, 16'(4 * ((r - 1) * (WPR + 1) + g + 1))}});
            end
            sb.push_back('{1'b1, DST + r * WPR + WPR - 1, {16'h5EED, 16'(4 * r * (WPR + 1))}});
        end
        rd_n = 0; wr_n = 0; shifts = 0; done_n = 0; log_n = 0;
        result = {16'h5EED, 16'h0};
    endtask

    task automatic run_frame(input vec_t v);
        int cyc;
        prep();
        max_lat = v.max_lat;
        lat     = $urandom_range(1, max_lat);
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_stb", 64'({stb, we, adr}), 64'({1'b1, 1'b0, 16'h0}));
        cyc = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk); #1;
            cyc++;
            start = v.spam && (done || $urandom_range(0, 5) == 0);
        end
        check("done_seen", 64'(done), 64'(1));
        if (v.exp_cyc != 0) check("frame_cycles", 64'(cyc), 64'(v.exp_cyc));
        @(negedge clk); #1 start = 1'b0;
        check("idle_after_done", 64'({busy, stb, done}), 64'(0));
        repeat (4) @(negedge clk);
        #1;
        check("done_count", 64'(done_n), 64'(1));
        check("sb_empty", 64'(sb.size()), 64'(0));
        check("rd_count", 64'(rd_n), 64'(v.exp_rd));
        check("wr_count", 64'(wr_n), 64'(v.exp_wr));
    endtask

    vec_t tbl[4];
    int   exp_first[8];

    initial begin
        tbl[0] = '{1, 1'b0, 61, 12, 4};
        tbl[1] = '{7, 1'b0, 0, 12, 4};
        tbl[2] = '{4, 1'b1, 0, 12, 4};
        tbl[3] = '{1, 1'b1, 61, 12, 4};
        exp_first = '{0, 2, 4, 1, 3, 5, 18, 19};
        rst = 1'b1; start = 1'b0; rdat = 32'h0; result = 32'h0;
        #1;
        check("rst_ctrl", 64'({busy, done, stb, we, ld_prev, ld_curr, ld_next, shift_en}), 64'(0));
        check("rst_adr", 64'(adr), 64'(0));
        check("rst_dat", 64'({dat, wdat}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i]);
            if (i == 0)
                for (int k = 0; k < 8; k++) check("first_order", 64'(log_adr[k]), 64'(exp_first[k]));
        end

        // A stray ack while idle must not start anything.
        @(negedge clk); #1 spur = 1'b1;
        @(negedge clk); #1 spur = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("stray_ack", 64'({busy, stb, done}), 64'(0));
        check("stray_ack_rd", 64'(rd_n), 64'(12));

        // Reset during the third shift of row 2 abandons the frame.
        begin
            int cyc;
            prep();
            max_lat = 1;
            lat     = 1;
            @(negedge clk); #1 start = 1'b1;
            @(negedge clk); #1 start = 1'b0;
            cyc = 0;
            while (!(shift_en && shifts == 15) && cyc < 2000) begin
                @(negedge clk); #1;
                cyc++;
            end
            check("abort_reached", 64'({shift_en, 16'(shifts)}), 64'({1'b1, 16'd15}));
            rst = 1'b1;
            #1;
            check("abort_ctrl", 64'({busy, done, stb, we, ld_prev, ld_curr, ld_next, shift_en}), 64'(0));
            check("abort_bus", 64'({adr, wdat[15:0]}), 64'(0));
            check("abort_dat", 64'(dat), 64'(0));
            @(negedge clk); #1 rst = 1'b0;
            repeat (4) @(negedge clk);
            #1;
            check("abort_writes", 64'(wr_n), 64'(2));
            check("abort_no_done", 64'(done_n), 64'(0));
            check("abort_idle", 64'({busy, stb}), 64'(0));
        end
        run_frame(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
